// File: rtl/cve2_obi_mem_arbiter.sv
// ============================================================================
// Module   : cve2_obi_mem_arbiter
// Brief    : Two-to-one OBI memory arbiter sharing one memory port between the
//            instruction-fetch and data ports, with in-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cve2_obi_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    input  logic                                   instr_req_i,
    input  logic [31:0]                            instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    output logic                                   instr_err_o,

    input  logic                                   data_req_i,
    input  logic                                   data_we_i,
    input  logic [3:0]                             data_be_i,
    input  logic [31:0]                            data_addr_i,
    input  logic [31:0]                            data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [31:0]                            data_rdata_o,
    output logic                                   data_err_o,

    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [3:0]                             mem_be_o,
    output logic [31:0]                            mem_addr_o,
    output logic [31:0]                            mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [31:0]                            mem_rdata_i,
    input  logic                                   mem_err_i,

    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   protocol_err_o
);

    localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);
    localparam int unsigned PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    localparam logic [CNT_W-1:0] C_MAX_CNT  = CNT_W'(MaxOutstanding);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(MaxOutstanding - 1);
    localparam logic             C_OWN_INSTR = 1'b0;
    localparam logic             C_OWN_DATA  = 1'b1;

    // Registered state
    logic                   r_lock_valid;
    logic                   r_lock_owner;
    logic                   r_last_grant;
    logic [CNT_W-1:0]       r_count;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic                   r_fifo [MaxOutstanding];
    logic                   r_protocol_err;

    // Combinational wires
    logic                   w_owner;
    logic                   w_owner_req;
    logic                   w_not_full;
    logic                   w_mem_req;
    logic                   w_grant;
    logic                   w_nonempty;
    logic                   w_head;
    logic                   w_push;
    logic                   w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A pending wait-stated request keeps its owner so the address stays stable.
    always_comb begin
        w_owner = C_OWN_INSTR;
        if (r_lock_valid) begin
            w_owner = r_lock_owner;
        end else if (instr_req_i && !data_req_i) begin
            w_owner = C_OWN_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            w_owner = C_OWN_DATA;
        end else if (instr_req_i && data_req_i) begin
            w_owner = ~r_last_grant;
        end
    end

    assign w_owner_req = (w_owner == C_OWN_DATA) ? data_req_i : instr_req_i;
    assign w_not_full  = (r_count < C_MAX_CNT);
    assign w_mem_req   = w_owner_req & w_not_full;
    assign w_grant     = w_mem_req & mem_gnt_i;

    assign w_nonempty  = (r_count != '0);
    assign w_head      = r_fifo[r_rptr];
    assign w_push      = w_grant;
    assign w_pop       = mem_rvalid_i & w_nonempty;

    // Request side
    always_comb begin
        mem_req_o   = w_mem_req;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_owner_req) begin
            if (w_owner == C_OWN_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o = w_grant & (w_owner == C_OWN_INSTR);
    assign data_gnt_o  = w_grant & (w_owner == C_OWN_DATA);

    // Response side: routing follows the owner of the oldest outstanding entry
    assign instr_rvalid_o = w_pop & (w_head == C_OWN_INSTR);
    assign data_rvalid_o  = w_pop & (w_head == C_OWN_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign outstanding_o  = r_count;
    assign protocol_err_o = r_protocol_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_valid   <= 1'b0;
            r_lock_owner   <= C_OWN_INSTR;
            r_last_grant   <= C_OWN_DATA;
            r_count        <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_protocol_err <= 1'b0;
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                r_fifo[i] <= C_OWN_INSTR;
            end
        end else begin
            if (w_mem_req && !mem_gnt_i) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_owner;
            end else if (w_grant) begin
                r_lock_valid <= 1'b0;
            end

            if (w_grant) begin
                r_last_grant <= w_owner;
            end

            if (w_push) begin
                r_fifo[r_wptr] <= w_owner;
                r_wptr         <= ptr_next(r_wptr);
            end

            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A response with nothing outstanding is a memory-side protocol breach
            if (mem_rvalid_i && !w_nonempty) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cve2_obi_mem_arbiter.sv
// ============================================================================
// Module   : tb_cve2_obi_mem_arbiter
// Brief    : Scoreboard bench for the two-to-one OBI memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cve2_obi_mem_arbiter;

    localparam int unsigned MAX_OUT = 2;
    localparam logic [31:0] C_IADDR = 32'h0000_1000;
    localparam logic [31:0] C_DADDR = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [$clog2(MAX_OUT+1)-1:0] outstanding;
    logic        protocol_err;

    int n_vec = 0;
    int n_err = 0;
    logic exp_q[$];

    cve2_obi_mem_arbiter #(.MaxOutstanding(MAX_OUT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err),
        .outstanding_o  (outstanding),
        .protocol_err_o (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected owner and check the response lands on that port.
    task automatic check_resp(input string tag);
        logic own;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            own = exp_q.pop_front();
            chk({tag, "_irv"}, 32'(instr_rvalid), 32'(own == 1'b0));
            chk({tag, "_drv"}, 32'(data_rvalid), 32'(own == 1'b1));
            chk({tag, "_rdata"}, own ? data_rdata : instr_rdata, mem_rdata);
            chk({tag, "_err"}, own ? 32'(data_err) : 32'(instr_err), 32'(mem_err));
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = C_IADDR;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        data_addr = C_DADDR; data_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #2;
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_outst", 32'(outstanding), 32'd0);
        chk("rst_perr", 32'(protocol_err), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_gnts", {30'd0, instr_gnt, data_gnt}, 32'd0);
        tick();

        // Contention: alternating grants starting with instr, responses next cycle
        instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = (k > 0);
            mem_rdata  = 32'hA000_0000 + 32'(k);
            mem_err    = (k == 2);
            #2;
            if (k > 0) check_resp("cont_resp");
            chk("cont_igrant", 32'(instr_gnt), 32'(k % 2 == 0));
            chk("cont_dgrant", 32'(data_gnt), 32'(k % 2 == 1));
            chk("cont_addr", mem_addr, (k % 2 == 0) ? C_IADDR : C_DADDR);
            chk("cont_outst", 32'(outstanding), (k > 0) ? 32'd1 : 32'd0);
            exp_q.push_back(k[0]);
            tick();
        end
        instr_req = 1'b0; data_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hA000_0004; mem_err = 1'b0;
        #2;
        check_resp("cont_last");
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk("cont_drained", 32'(outstanding), 32'd0);
        tick();

        // Wait-state lock, with a write sitting on the data port
        data_we = 1'b1; data_be = 4'b0110; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
        instr_req = 1'b1; mem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_req = (c >= 1);
            #2;
            chk("lock_req", 32'(mem_req), 32'd1);
            chk("lock_addr", mem_addr, C_IADDR);
            chk("lock_gnts", {30'd0, instr_gnt, data_gnt}, 32'd0);
            if (c == 2) begin
                chk("ifetch_we", 32'(mem_we), 32'd0);
                chk("ifetch_be", 32'(mem_be), 32'hF);
                chk("ifetch_wdata", mem_wdata, 32'h0);
            end
            tick();
        end
        mem_gnt = 1'b1;
        #2;
        chk("lock_igrant", 32'(instr_gnt), 32'd1);
        chk("lock_dgrant", 32'(data_gnt), 32'd0);
        exp_q.push_back(1'b0);
        tick();
        instr_req = 1'b0;
        #2;
        chk("wr_dgrant", 32'(data_gnt), 32'd1);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_be", 32'(mem_be), 32'h6);
        chk("wr_addr", mem_addr, 32'h100);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        exp_q.push_back(1'b1);
        tick();
        data_req = 1'b0; data_we = 1'b0; data_be = 4'hF;
        for (int r = 0; r < 2; r++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hB000_0000 + 32'(r);
            #2;
            check_resp("lock_resp");
            tick();
        end
        mem_rvalid = 1'b0;

        // Full limit: two grants without responses block the third
        data_req = 1'b1; mem_gnt = 1'b1;
        for (int g = 0; g < 2; g++) begin
            #2;
            chk("full_dgrant", 32'(data_gnt), 32'd1);
            exp_q.push_back(1'b1);
            tick();
        end
        #2;
        chk("full_memreq", 32'(mem_req), 32'd0);
        chk("full_outst", 32'(outstanding), 32'd2);
        chk("full_dgrant0", 32'(data_gnt), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hC000_0000;
        #2;
        check_resp("full_resp");
        chk("full_stillblk", 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk("full_regrant", 32'(data_gnt), 32'd1);
        chk("full_outst1", 32'(outstanding), 32'd1);
        exp_q.push_back(1'b1);
        tick();
        data_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hC000_0001;
        #2;
        check_resp("full_drain");
        tick();

        // Simultaneous push and pop at count 1; response goes to the older owner
        instr_req = 1'b1; mem_rdata = 32'hD000_0000;
        #2;
        chk("pp_outst_before", 32'(outstanding), 32'd1);
        check_resp("pp_resp");
        chk("pp_igrant", 32'(instr_gnt), 32'd1);
        exp_q.push_back(1'b0);
        tick();
        instr_req = 1'b0; mem_rdata = 32'hD000_0001;
        #2;
        chk("pp_outst_after", 32'(outstanding), 32'd1);
        check_resp("pp_resp2");
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk("pp_empty", 32'(outstanding), 32'd0);
        tick();

        // Unexpected response with nothing outstanding
        mem_rvalid = 1'b1; mem_rdata = 32'hE000_0000;
        #2;
        chk("unexp_irv", 32'(instr_rvalid), 32'd0);
        chk("unexp_drv", 32'(data_rvalid), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("unexp_sticky", 32'(protocol_err), 32'd1);
            chk("unexp_outst", 32'(outstanding), 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("unexp_cleared", 32'(protocol_err), 32'd0);
        chk("final_qempty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cve2_obi_mem_arbiter.md
# cve2_obi_mem_arbiter

Two-to-one OBI-style memory arbiter. It lets the core's instruction-fetch port and data port share a single memory port, for single-port SRAM integrations of the core. It arbitrates requests round-robin and tracks up to `MaxOutstanding` accepted transactions in an owner FIFO. In-order responses are routed back to the requester that issued them.

## Interface
Parameters:
- `MaxOutstanding`, default 2: maximum accepted-but-unanswered transactions; legal range 1..8.

Ports:
- `clk_i` input 1: clock; single clock domain.
- `rst_i` input 1: synchronous, active-high reset.
- `instr_req_i` input 1: fetch request; held with stable address until granted.
- `instr_addr_i` input 32: fetch address.
- `instr_gnt_o` output 1: fetch request accepted this cycle.
- `instr_rvalid_o` output 1: fetch response valid.
- `instr_rdata_o` output 32: fetch response data.
- `instr_err_o` output 1: fetch response error.
- `data_req_i` input 1: data request; held with stable attributes until granted.
- `data_we_i` input 1: write enable.
- `data_be_i` input 4: byte enables.
- `data_addr_i` input 32: data address.
- `data_wdata_i` input 32: write data.
- `data_gnt_o` output 1: data request accepted.
- `data_rvalid_o` output 1: data response valid.
- `data_rdata_o` output 32: data response data.
- `data_err_o` output 1: data response error.
- `mem_req_o` output 1: shared-port request.
- `mem_we_o` output 1: shared-port write enable.
- `mem_be_o` output 4: shared-port byte enables.
- `mem_addr_o` output 32: shared-port address.
- `mem_wdata_o` output 32: shared-port write data.
- `mem_gnt_i` input 1: memory accepts request.
- `mem_rvalid_i` input 1: memory response valid; responses arrive in order.
- `mem_rdata_i` input 32: memory response data.
- `mem_err_i` input 1: memory response error.
- `outstanding_o` output `$clog2(MaxOutstanding+1)`: current outstanding count.
- `protocol_err_o` output 1: sticky; set when `mem_rvalid_i` arrives with zero transactions outstanding.

## Operation
- **Owner selection** (combinational), in priority order:
  - If the lock is valid, the owner is the locked requester.
  - Otherwise, if exactly one requester is requesting, it is the owner.
  - Otherwise, if both are requesting, the owner is the requester other than `last_grant`.
- **Request forwarding:** `mem_req_o` = owner's req AND (`outstanding_o` < `MaxOutstanding`).
- **Instruction owner:** `mem_we_o` = 0, `mem_be_o` = 4'hF, `mem_wdata_o` = 0.
- **Data owner:** data attributes pass through unchanged.
- **Grant:** owner's `gnt_o` = `mem_req_o` AND `mem_gnt_i`. The non-owner's `gnt_o` is 0.
- **Lock register:**
  - Set with the owner ID when `mem_req_o` is 1 and `mem_gnt_i` is 0. This keeps OBI address stability.
  - Cleared on grant.
  - The lock cannot persist while full: count only rises on a grant.
- **`last_grant` register:** updated to the granted owner on every grant.
- **Owner FIFO** (depth `MaxOutstanding`, 1-bit entries, 0 = instr, 1 = data):
  - Push on grant.
  - Pop on `mem_rvalid_i`.
  - Simultaneous push and pop is legal and leaves the count unchanged.
  - Read/write pointers wrap modulo `MaxOutstanding`.
- **Response routing:**
  - FIFO head = 0: `instr_rvalid_o` = `mem_rvalid_i`.
  - FIFO head = 1: `data_rvalid_o` = `mem_rvalid_i`.
  - `rdata`/`err` are broadcast to both ports; they are meaningful only with `rvalid`.
- **Unexpected response:** `mem_rvalid_i` with count 0 does not pop, asserts neither `rvalid_o`, and sets `protocol_err_o`. The flag is cleared only by reset.

## Timing
- **Reset:** after `rst_i` is sampled high, count = 0, FIFO is empty, lock is cleared, `last_grant` = data (so the first contended grant goes to instr), and `protocol_err_o` = 0. All outputs are 0 while no request is pending.
- **Request path:** zero-cycle, combinational from `*_req_i` to `mem_req_o` and from `mem_gnt_i` to `*_gnt_o`.
- **Response path:** zero-cycle, combinational from `mem_rvalid_i` to `*_rvalid_o`.
- **Bookkeeping:** `outstanding_o` updates the cycle after a grant or response edge.
- **Back-to-back:** with `mem_gnt_i` held high and both requesters active, grants alternate instr, data, instr, … every cycle, subject to the count limit.
- **Full:** when count = `MaxOutstanding`, `mem_req_o` = 0. A response in cycle N allows a new grant in cycle N+1.
- **Reset mid-operation:** outstanding state is discarded. The memory is reset in the same cycle, so no late responses are expected; any that arrive set `protocol_err_o`.

## Test plan
- **Contention:** reset, then hold both reqs with `mem_gnt_i` = 1 and each rvalid returned the next cycle. Required: grants instr, data, instr, data; rvalids routed in the same order; `outstanding_o` ≤ 1.
- **Wait-state lock:** `instr_req_i` rises and `mem_gnt_i` = 0 for 3 cycles, while `data_req_i` rises in cycle 1. Required: `mem_addr_o` stays at the instr address for all 3 cycles; the data request is granted only after the instr grant.
- **Full limit:** `MaxOutstanding` = 2, data reqs granted twice with no rvalid. Required: `mem_req_o` = 0 and `outstanding_o` = 2. After one rvalid, the next cycle grants.
- **Simultaneous push/pop at count 1:** required: `outstanding_o` stays 1; the response goes to the older owner.
- **Write attributes:** data write with be = 4'b0110, addr 0x100, wdata 0xDEADBEEF. Required: passed unchanged to `mem_*`. An instr fetch drives we = 0, be = 4'hF.
- **Unexpected response:** `mem_rvalid_i` with count 0. Required: no `rvalid_o`; `protocol_err_o` = 1 and stays 1 until `rst_i`.
